// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO port responder: register word offsets,
// timer control bit indices and the default window base.
package mmio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0400;

    localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
    localparam logic [2:0] OFF_PORT_IN   = 3'd1;
    localparam logic [2:0] OFF_EDGE      = 3'd2;
    localparam logic [2:0] OFF_EDGE_MASK = 3'd3;
    localparam logic [2:0] OFF_TMR_CTRL  = 3'd4;
    localparam logic [2:0] OFF_TMR_LOAD  = 3'd5;
    localparam logic [2:0] OFF_TMR_COUNT = 3'd6;
    localparam logic [2:0] OFF_STATUS    = 3'd7;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_TIE  = 2;

endpackage

// File: rtl/mmio_timer.sv
// Prescaled down-counter timer with reload, auto-restart and sticky expiry.
// Instantiated by mmio_port_responder only when MMIO_TIMER_EN is defined.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrlWr,
    input  logic        loadWr,
    input  logic        statusW1c,
    input  logic [31:0] wrData,
    output logic [2:0]  ctrl,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic        exp
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [15:0] pre;
    logic        tick;
    logic        expire;

    assign tick   = ctrl[CTRL_EN] && (pre == PRE_MAX);
    assign expire = tick && (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre   <= '0;
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
            exp   <= 1'b0;
        end else begin
            if (!ctrl[CTRL_EN] || tick) begin
                pre <= '0;
            end else begin
                pre <= pre + 16'd1;
            end

            // A CPU write to CTRL wins over the hardware EN clear.
            if (ctrlWr) begin
                ctrl <= wrData[2:0];
            end else if (expire && !ctrl[CTRL_AUTO]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (loadWr) begin
                load <= wrData;
            end

            if (tick) begin
                if (count != '0) begin
                    count <= count - 32'd1;
                end else if (ctrl[CTRL_AUTO]) begin
                    count <= load;
                end
            end else if (loadWr && !ctrl[CTRL_EN]) begin
                count <= wrData;
            end

            exp <= (exp & ~(statusW1c & wrData[0])) | expire;
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder: output port, synchronized input port with edge flags and,
// when MMIO_TIMER_EN is defined, a prescaled down-counter timer.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        Irq
);

    logic [2:0]  wordOff;
    logic        wrEn;
    logic        unusedBits;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  syncPrev;
    logic [7:0]  edgeFlags;
    logic [7:0]  edgeMask;
    logic [2:0]  tmrCtrl;
    logic [31:0] tmrLoad;
    logic [31:0] tmrCount;
    logic        tmrExp;
    logic [31:0] rdMux;

    assign Hit        = (Address[31:5] == BASE_ADDR[31:5]);
    assign wordOff    = Address[4:2];
    assign wrEn       = MemWrite & Hit;
    assign unusedBits = ^Address[1:0];

`ifdef MMIO_TIMER_EN
    mmio_timer #(
        .PRESCALE (PRESCALE)
    ) uTimer (
        .clk       (clk),
        .reset     (reset),
        .ctrlWr    (wrEn && (wordOff == OFF_TMR_CTRL)),
        .loadWr    (wrEn && (wordOff == OFF_TMR_LOAD)),
        .statusW1c (wrEn && (wordOff == OFF_STATUS)),
        .wrData    (WriteData),
        .ctrl      (tmrCtrl),
        .load      (tmrLoad),
        .count     (tmrCount),
        .exp       (tmrExp)
    );
`else
    assign tmrCtrl  = '0;
    assign tmrLoad  = '0;
    assign tmrCount = '0;
    assign tmrExp   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            syncPrev  <= '0;
            edgeFlags <= '0;
            edgeMask  <= '0;
            PortOut   <= '0;
            Irq       <= 1'b0;
        end else begin
            sync1    <= PortIn;
            sync2    <= sync1;
            syncPrev <= sync2;
            // New rises are OR-ed in after the clear so a set wins.
            edgeFlags <= (edgeFlags
                          & ~((wrEn && (wordOff == OFF_EDGE))
                              ? WriteData[7:0] : 8'h00))
                         | (sync2 & ~syncPrev);
            if (wrEn && (wordOff == OFF_EDGE_MASK)) begin
                edgeMask <= WriteData[7:0];
            end
            if (wrEn && (wordOff == OFF_PORT_OUT)) begin
                PortOut <= WriteData;
            end
            Irq <= (|(edgeFlags & edgeMask)) | (tmrExp & tmrCtrl[CTRL_TIE]);
        end
    end

    always_comb begin
        rdMux = '0;
        case (wordOff)
            OFF_PORT_OUT:  rdMux = PortOut;
            OFF_PORT_IN:   rdMux = {24'b0, sync2};
            OFF_EDGE:      rdMux = {24'b0, edgeFlags};
            OFF_EDGE_MASK: rdMux = {24'b0, edgeMask};
            OFF_TMR_CTRL:  rdMux = {29'b0, tmrCtrl};
            OFF_TMR_LOAD:  rdMux = tmrLoad;
            OFF_TMR_COUNT: rdMux = tmrCount;
            OFF_STATUS:    rdMux = {31'b0, tmrExp | (unusedBits & 1'b0)};
            default:       rdMux = '0;
        endcase
    end

    assign ReadData = (MemRead && Hit) ? rdMux : 32'h0;

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the MIPS core's data-memory bus: the target side of the core's load/store interface. Sits beside DataMemory, decodes a small register window, and serves an output port, a synchronized input port with sticky edge flags, and a prescaled down-counter timer. The top level muxes `ReadData` with DataMemory's read data using `Hit`.

## Interface
- `BASE_ADDR`, default 32'h1001_0400: byte base of the 32-byte register window; bits [4:0] are ignored.
- `PRESCALE`, default 4: timer decrements once every PRESCALE clocks; legal range 1..65535.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `Address`  in  32  byte address from the core's ALU result.
- `WriteData`  in  32  store data (core ReadData2).
- `MemWrite`  in  1  store strobe, qualified by the window decode.
- `MemRead`  in  1  load strobe, qualified by the window decode.
- `PortIn`  in  8  asynchronous external inputs.
- `ReadData`  out  32  combinational read data; 0 when not (`MemRead` & `Hit`).
- `Hit`  out  1  combinational: `Address[31:5] == BASE_ADDR[31:5]`.
- `PortOut`  out  32  registered output port.
- `Irq`  out  1  registered level interrupt.

## Operation
- Word offset is `Address[4:2]`; `Address[1:0]` is ignored. Only full-word accesses are supported.
- 0x00 PORT_OUT RW: drives `PortOut`.
- 0x04 PORT_IN RO: `{24'b0, sync2}`, where sync2 is the second stage of a 2-flop synchronizer on `PortIn`.
- 0x08 EDGE RW1C: bit i sets when sync2[i] rises (sync2 = 1, previous sample = 0). Writing 1 to a bit clears it. Bits [31:8] read 0.
- 0x0C EDGE_MASK RW [7:0]: enables each EDGE bit into `Irq`.
- 0x10 TMR_CTRL RW: bit0 EN, bit1 AUTO, bit2 TIE (timer interrupt enable). Other bits read 0.
- 0x14 TMR_LOAD RW: reload value. A write while EN = 0 also copies the value into COUNT.
- 0x18 TMR_COUNT RO: current count.
- 0x1C STATUS RW1C: bit0 EXP (timer expired, sticky).
- A write takes effect only when `MemWrite` & `Hit`. Writes to RO or reserved offsets are ignored; reads from reserved offsets return 0.
- Timer behaviour:
  - While EN = 1, the prescaler counts 0..PRESCALE-1; each wrap is a tick.
  - On a tick with COUNT > 0: COUNT decrements.
  - On a tick with COUNT == 0: EXP sets. If AUTO = 1, COUNT reloads from LOAD. If AUTO = 0, EN clears and COUNT holds at 0.
  - While EN = 0, the prescaler is held at 0.
- Irq next value = `|(EDGE & EDGE_MASK)` | (EXP & TIE).
- Simultaneous events:
  - Set beats W1C clear on the same cycle, for both EDGE and EXP.
  - A CPU write to TMR_CTRL beats the hardware EN clear in the same cycle.
  - A LOAD write in the same cycle as a tick: the tick uses the old COUNT, and the write is ignored because EN = 1.

## Timing
- Reset, with `reset` = 0 at a clock edge: all registers, synchronizer stages, prescaler, COUNT, `PortOut`, and `Irq` go to 0. Reset asserted mid-operation aborts the timer immediately; there is no partial state.
- `ReadData` and `Hit` are combinational, so a load completes in the same cycle, matching the single-cycle core. `ReadData` returns pre-edge register values.
- A store is visible in its register, and on `PortOut`, one cycle after the write edge.
- `PortIn` to PORT_IN read: 2 cycles. `PortIn` to EDGE flag set: 3 cycles. EDGE flag to `Irq`: +1 cycle.
- The first tick occurs PRESCALE cycles after EN is written to 1. EXP rises on the edge where the tick sees COUNT == 0; `Irq` follows 1 cycle later.

## Configuration
- `MMIO_TIMER_EN` defined: the timer, TMR_* registers and STATUS.EXP are present.
- `MMIO_TIMER_EN` undefined: the timer logic is not instantiated. Offsets 0x0C is unaffected; 0x10–0x1C read 0 and writes to them are ignored. EXP is constant 0, so `Irq` depends only on EDGE.

## Structure
- Shared package `mmio_pkg`:
  - Register offset constants OFF_PORT_OUT … OFF_STATUS.
  - TMR_CTRL bit-index constants.
  - Default base address constant.
- Sub-module `mmio_timer`, instantiated under `MMIO_TIMER_EN`:
  - Contains the prescaler, COUNT, LOAD, CTRL and EXP.
  - Exposes write strobes, W1C inputs, and register read values.

## Test plan
- Reset hold 2 cycles, then read all 8 offsets → all return 0; `PortOut` = 0 and `Irq` = 0.
- Store 0xDEADBEEF to 0x1001_0400 → `PortOut` = 0xDEADBEEF the next cycle. Store to 0x1001_0800 → `Hit` = 0 and `PortOut` unchanged.
- `PortIn` 0x00→0x05, EDGE_MASK = 0x01 → EDGE reads 0x05 after 3 cycles and `Irq` = 1 one cycle later. W1C 0x01 on the same cycle as a new bit-0 rise → bit 0 stays set.
- PRESCALE = 4, LOAD = 3, CTRL = EN|AUTO|TIE → COUNT reads 3, 2, 1, 0 at 4-cycle spacing. EXP sets on the next tick, COUNT returns to 3, and `Irq` = 1. W1C to STATUS bit0 → `Irq` drops the following cycle.
- CTRL = EN (no AUTO), LOAD = 1 → after the expiring tick, EN reads 0, COUNT holds at 0, and EXP = 1.
- Build without `MMIO_TIMER_EN`: write 0x7 to 0x10 and 0xFFFF to 0x14 → reads return 0 and `Irq` stays 0.
